// File: rtl/alu_issue_pkg.sv
// Purpose : shared types and constants for the ALU issue/retire pipeline.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: datapath width, RV32I opcode constants, and the 4-bit ALU
// operation codes that the shared ALU understands.
package alu_issue_pkg;

  localparam int XLEN = 32;

  // RV32I major opcodes handled by the issue stage.
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // ALU operation codes; ALU_ADD is the idle/reset code.
  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_LSL    = 4'd5,
    ALU_LSR    = 4'd6,
    ALU_PASS_1 = 4'd7
  } alu_op_e;

  // Decoded instruction as held in the D stage register.
  typedef struct packed {
    alu_op_e         op;
    logic [XLEN-1:0] in_0;
    logic [XLEN-1:0] in_1;
    logic [4:0]      rd;
    logic            we;
    logic            branch;
    logic            is_bne;
    logic            illegal;
  } dec_t;

endpackage

// File: rtl/alu_decode.sv
// Purpose : combinational RV32I decode of OP/OP-IMM/LUI/BEQ/BNE into ALU op + operands.
// Latency : 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
//
// Ports: instr/rs1/rs2 in; op, in_0, in_1, rd, we, branch, is_bne, illegal out.
module alu_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [3:0]      op,
  output logic [XLEN-1:0] in_0,
  output logic [XLEN-1:0] in_1,
  output logic [4:0]      rd,
  output logic            we,
  output logic            branch,
  output logic            is_bne,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic            legal;
  alu_op_e         op_e;

  // rs1 register-index field is resolved upstream; not needed here.
  logic unused_rs1_idx;
  assign unused_rs1_idx = ^instr[19:15];

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];
  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};

  always_comb begin
    op_e   = ALU_ADD;
    in_0   = '0;
    in_1   = '0;
    branch = 1'b0;
    is_bne = 1'b0;
    legal  = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        in_0  = rs1;
        in_1  = rs2;
        legal = 1'b1;
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: op_e = ALU_ADD;
            3'b100: op_e = ALU_XOR;
            3'b110: op_e = ALU_OR;
            3'b111: op_e = ALU_AND;
            // The ALU shifts by its whole second operand, so keep only
            // the architectural 5-bit shift amount.
            3'b001: begin op_e = ALU_LSL; in_1 = {{(XLEN-5){1'b0}}, rs2[4:0]}; end
            3'b101: begin op_e = ALU_LSR; in_1 = {{(XLEN-5){1'b0}}, rs2[4:0]}; end
            default: legal = 1'b0;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          op_e = ALU_SUB;
        end else begin
          legal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        in_0  = rs1;
        in_1  = imm_i;
        legal = 1'b1;
        case (funct3)
          3'b000: op_e = ALU_ADD;
          3'b100: op_e = ALU_XOR;
          3'b110: op_e = ALU_OR;
          3'b111: op_e = ALU_AND;
          // SRAI shares funct3 101 with a non-zero funct7; reject it.
          3'b001: begin op_e = ALU_LSL; in_1 = {{(XLEN-5){1'b0}}, instr[24:20]}; legal = (funct7 == 7'b0); end
          3'b101: begin op_e = ALU_LSR; in_1 = {{(XLEN-5){1'b0}}, instr[24:20]}; legal = (funct7 == 7'b0); end
          default: legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        op_e  = ALU_PASS_1;
        in_1  = imm_u;
        legal = 1'b1;
      end
      OPC_BRANCH: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          op_e   = ALU_SUB;
          in_0   = rs1;
          in_1   = rs2;
          branch = 1'b1;
          is_bne = funct3[0];
          legal  = 1'b1;
        end
      end
      default: legal = 1'b0;
    endcase

    // Unsupported encodings issue a harmless ADD 0,0.
    if (!legal) begin
      op_e   = ALU_ADD;
      in_0   = '0;
      in_1   = '0;
      branch = 1'b0;
      is_bne = 1'b0;
    end
  end

  assign op      = op_e;
  assign illegal = !legal;
  assign we      = legal && !branch && (rd != 5'd0);

endmodule

// File: rtl/alu_issue.sv
// Purpose : two-stage issue (D) / retire (R) pipeline driving the shared combinational ALU.
// Latency : 2 cycles accept-to-res_valid, 1 instruction/cycle with res_ready high.
// Backpressure: res_ready low holds R then D; instr_ready drops once D cannot advance.
//
// Ports: clk/reset/flush; instr_valid/instr_ready/instr/rs1_val/rs2_val from operand
// fetch; alu_op/alu_in_0/alu_in_1 to the ALU, alu_out/alu_zero back; res_* to writeback.
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_in_0,
  output logic [XLEN-1:0] alu_in_1,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_zero,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data,
  output logic [4:0]      res_rd,
  output logic            res_we,
  output logic            res_branch,
  output logic            res_taken,
  output logic            res_illegal
);

  logic [3:0] dec_op;
  dec_t       dec;
  dec_t       d_q;
  logic       d_valid;
  logic       d_adv;
  logic       accept;

  alu_decode u_decode (
    .instr   (instr),
    .rs1     (rs1_val),
    .rs2     (rs2_val),
    .op      (dec_op),
    .in_0    (dec.in_0),
    .in_1    (dec.in_1),
    .rd      (dec.rd),
    .we      (dec.we),
    .branch  (dec.branch),
    .is_bne  (dec.is_bne),
    .illegal (dec.illegal)
  );
  assign dec.op = alu_op_e'(dec_op);

  // D moves into R whenever R is empty or being drained this cycle.
  assign d_adv       = d_valid && (!res_valid || res_ready);
  assign instr_ready = !flush && (!d_valid || d_adv);
  assign accept      = instr_valid && instr_ready;

  // D stage: data registers only load on accept so the ALU inputs stay
  // stable while an instruction is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_valid <= 1'b0;
      d_q     <= '0;
    end else if (flush) begin
      d_valid <= 1'b0;
    end else if (accept) begin
      d_valid <= 1'b1;
      d_q     <= dec;
    end else if (d_adv) begin
      d_valid <= 1'b0;
    end
  end

  assign alu_op   = d_q.op;
  assign alu_in_0 = d_q.in_0;
  assign alu_in_1 = d_q.in_1;

  // R stage: captures the ALU result as D advances; a simultaneous pop
  // and load keeps res_valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_rd      <= '0;
      res_we      <= 1'b0;
      res_branch  <= 1'b0;
      res_taken   <= 1'b0;
      res_illegal <= 1'b0;
    end else if (flush) begin
      res_valid <= 1'b0;
    end else if (d_adv) begin
      res_valid   <= 1'b1;
      res_data    <= alu_out;
      res_rd      <= d_q.rd;
      res_we      <= d_q.we;
      res_branch  <= d_q.branch;
      res_taken   <= d_q.branch & (d_q.is_bne ? !alu_zero : alu_zero);
      res_illegal <= d_q.illegal;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU and an in-order
// result scoreboard; expected results are supplied with each instruction.
module tb_alu_issue;
  import alu_issue_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, instr_valid, instr_ready;
  logic [31:0] instr, rs1_val, rs2_val;
  logic [3:0]  alu_op;
  logic [31:0] alu_in_0, alu_in_1, alu_out;
  logic        alu_zero;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_we, res_branch, res_taken, res_illegal;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        br;
    logic        tk;
    logic        ill;
  } exp_t;

  exp_t q[$];
  exp_t pend;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue dut (
    .clk(clk), .reset(reset), .flush(flush),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .alu_op(alu_op), .alu_in_0(alu_in_0), .alu_in_1(alu_in_1),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_rd(res_rd), .res_we(res_we), .res_branch(res_branch),
    .res_taken(res_taken), .res_illegal(res_illegal)
  );

  // Behavioural model of the shared ALU.
  always_comb begin
    alu_out = 32'h0;
    case (alu_op)
      ALU_ADD:    alu_out = alu_in_0 + alu_in_1;
      ALU_SUB:    alu_out = alu_in_0 - alu_in_1;
      ALU_AND:    alu_out = alu_in_0 & alu_in_1;
      ALU_OR:     alu_out = alu_in_0 | alu_in_1;
      ALU_XOR:    alu_out = alu_in_0 ^ alu_in_1;
      ALU_LSL:    alu_out = alu_in_0 << alu_in_1;
      ALU_LSR:    alu_out = alu_in_0 >> alu_in_1;
      ALU_PASS_1: alu_out = alu_in_1;
      default:    alu_out = 32'hdead_beef;
    endcase
    alu_zero = (alu_out == 32'h0);
  end

  function automatic logic [31:0] r_type(logic [6:0] f7, logic [4:0] s2, logic [4:0] s1,
                                         logic [2:0] f3, logic [4:0] rd);
    return {f7, s2, s1, f3, rd, OPC_OP};
  endfunction

  function automatic logic [31:0] i_type(logic [11:0] imm, logic [4:0] s1, logic [2:0] f3,
                                         logic [4:0] rd);
    return {imm, s1, f3, rd, OPC_OP_IMM};
  endfunction

  function automatic logic [31:0] b_type(logic [2:0] f3);
    return {7'b0, 5'd2, 5'd1, f3, 5'd0, OPC_BRANCH};
  endfunction

  function automatic exp_t mk(logic [31:0] d, logic [4:0] rd, logic we, logic br,
                              logic tk, logic ill);
    exp_t e;
    e.data = d; e.rd = rd; e.we = we; e.br = br; e.tk = tk; e.ill = ill;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("res_data",    res_data,           e.data);
      chk("res_rd",      32'(res_rd),        32'(e.rd));
      chk("res_we",      32'(res_we),        32'(e.we));
      chk("res_branch",  32'(res_branch),    32'(e.br));
      chk("res_taken",   32'(res_taken),     32'(e.tk));
      chk("res_illegal", 32'(res_illegal),   32'(e.ill));
    end
  endtask

  // One clock: sample just after the negedge, then advance to the next negedge.
  task automatic cyc(output bit acc);
    #1;
    acc = instr_valid && instr_ready;
    if (res_valid && res_ready) pop_check();
    if (acc) q.push_back(pend);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(logic [31:0] ins, logic [31:0] a, logic [31:0] b, exp_t e);
    bit acc = 1'b0;
    instr = ins; rs1_val = a; rs2_val = b; pend = e;
    instr_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) cyc(acc);
    chk("send_accepted", 32'(acc), 32'd1);
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 20 && q.size() != 0; i++) cyc(acc);
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic check_reset_state();
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data",  res_data,       32'd0);
    chk("rst_res_rd",    32'(res_rd),    32'd0);
    chk("rst_res_we",    32'(res_we),    32'd0);
    chk("rst_alu_op",    32'(alu_op),    32'(ALU_ADD));
    chk("rst_alu_in_0",  alu_in_0,       32'd0);
    chk("rst_alu_in_1",  alu_in_1,       32'd0);
  endtask

  initial begin
    bit acc;
    reset = 1'b1; flush = 1'b0; instr_valid = 1'b0; res_ready = 1'b1;
    instr = 32'h0; rs1_val = 32'h0; rs2_val = 32'h0; pend = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check_reset_state();
    reset = 1'b0;
    #1 chk("rst_instr_ready", 32'(instr_ready), 32'd1);

    // ADD x3,x1,x2: 5+7, result two cycles after accept.
    send(r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7, mk(32'd12, 5'd3, 1, 0, 0, 0));
    chk("lat_d_only", 32'(res_valid), 32'd0);
    cyc(acc);
    chk("lat_res_valid", 32'(res_valid), 32'd1);
    drain();

    // SLL with oversized shift amount: masked to 1.
    send(r_type(7'b0, 5'd2, 5'd1, 3'b001, 5'd4), 32'd1, 32'h21, mk(32'd2, 5'd4, 1, 0, 0, 0));
    chk("sll_alu_in_1", alu_in_1, 32'd1);
    chk("sll_alu_op",   32'(alu_op), 32'(ALU_LSL));
    drain();

    // SRLI x7,x1,4 on 0x80000000.
    send(i_type(12'd4, 5'd1, 3'b101, 5'd7), 32'h8000_0000, 32'h0,
         mk(32'h0800_0000, 5'd7, 1, 0, 0, 0));
    // BNE / BEQ with equal operands.
    send(b_type(3'b001), 32'd9, 32'd9, mk(32'd0, 5'd0, 0, 1, 0, 0));
    send(b_type(3'b000), 32'd9, 32'd9, mk(32'd0, 5'd0, 0, 1, 1, 0));
    // SRA is unsupported; issues ADD 0,0.
    send(r_type(7'b0100000, 5'd2, 5'd1, 3'b101, 5'd5), 32'h1234, 32'd3,
         mk(32'd0, 5'd5, 0, 0, 0, 1));
    // LUI x6, 0x12345.
    send({20'h12345, 5'd6, OPC_LUI}, 32'hffff_ffff, 32'hffff_ffff,
         mk(32'h1234_5000, 5'd6, 1, 0, 0, 0));
    // SUB x8 and ADD to x0 (no write).
    send(r_type(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd8), 32'd3, 32'd5,
         mk(32'hffff_fffe, 5'd8, 1, 0, 0, 0));
    send(r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd0), 32'd3, 32'd5, mk(32'd8, 5'd0, 0, 0, 0, 0));
    drain();

    // Back-to-back ADDI x1..x4 with res_ready low for the first 3 cycles.
    begin
      int  idx = 0;
      bit  saw_stall = 1'b0;
      res_ready = 1'b0;
      for (int c = 0; c < 30 && idx < 4; c++) begin
        res_ready   = (c >= 3);
        instr_valid = 1'b1;
        instr       = i_type(12'(idx + 1), 5'd1, 3'b000, 5'(idx + 1));
        rs1_val     = 32'd100;
        pend        = mk(32'(101 + idx), 5'(idx + 1), 1, 0, 0, 0);
        #1 if (!instr_ready) saw_stall = 1'b1;
        cyc(acc);
        if (acc) idx++;
      end
      instr_valid = 1'b0;
      chk("stream_all_accepted", 32'(idx), 32'd4);
      chk("stream_saw_stall", 32'(saw_stall), 32'd1);
      res_ready = 1'b1;
      drain();
    end

    // Flush with both stages full and a competing instruction.
    res_ready = 1'b0;
    send(i_type(12'd1, 5'd1, 3'b000, 5'd1), 32'd0, 32'd0, mk(32'd1, 5'd1, 1, 0, 0, 0));
    send(i_type(12'd2, 5'd1, 3'b000, 5'd2), 32'd0, 32'd0, mk(32'd2, 5'd2, 1, 0, 0, 0));
    chk("pre_flush_res_valid", 32'(res_valid), 32'd1);
    flush = 1'b1; instr_valid = 1'b1;
    instr = i_type(12'd3, 5'd1, 3'b000, 5'd3); pend = mk(32'd3, 5'd3, 1, 0, 0, 0);
    #1 chk("flush_instr_ready", 32'(instr_ready), 32'd0);
    cyc(acc);
    chk("flush_not_accepted", 32'(acc), 32'd0);
    chk("flush_res_valid", 32'(res_valid), 32'd0);
    q.delete();
    flush = 1'b0; instr_valid = 1'b0;
    cyc(acc);
    chk("post_flush_res_valid", 32'(res_valid), 32'd0);
    res_ready = 1'b1;

    // Reset in the middle of a stall.
    res_ready = 1'b0;
    send(i_type(12'd7, 5'd1, 3'b000, 5'd9), 32'd1, 32'd0, mk(32'd8, 5'd9, 1, 0, 0, 0));
    send(i_type(12'd9, 5'd1, 3'b000, 5'd10), 32'd1, 32'd0, mk(32'd10, 5'd10, 1, 0, 0, 0));
    reset = 1'b1;
    cyc(acc);
    check_reset_state();
    q.delete();
    reset = 1'b0; res_ready = 1'b1;
    #1 chk("post_rst_instr_ready", 32'(instr_ready), 32'd1);

    // Pipeline still works after reset: XORI x11.
    send(i_type(12'h0ff, 5'd1, 3'b100, 5'd11), 32'h0000_0f0f, 32'h0,
         mk(32'h0000_0ff0, 5'd11, 1, 0, 0, 0));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Two-stage issue/retire pipeline that drives the shared RV32I ALU. It decodes OP, OP-IMM, LUI and BEQ/BNE instructions into 4-bit ALU operation codes and operands, and presents them to the combinational ALU. It then captures the ALU result and zero flag into a result register with a valid/ready handshake toward writeback. It sits between operand fetch (register-file read) and writeback.

## Interface
- XLEN, 32 (from RISCV.h): datapath width.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- flush  in  1  synchronous; drops both stages' valid bits.
- instr_valid  in  1  upstream instruction/operands valid.
- instr_ready  out  1  upstream accepted this cycle when high with instr_valid.
- instr  in  32  RV32I instruction word.
- rs1_val, rs2_val  in  XLEN  register operands.
- alu_op  out  4  ALU operation code (alu_codes.h).
- alu_in_0, alu_in_1  out  XLEN  ALU operands.
- alu_out  in  XLEN  ALU result (combinational from alu_op/alu_in_*).
- alu_zero  in  1  ALU zero flag.
- res_valid  out  1  result register valid.
- res_ready  in  1  writeback accepts result.
- res_data  out  XLEN  captured alu_out.
- res_rd  out  5  destination register.
- res_we  out  1  register write enable (0 for branch, illegal, rd==0).
- res_branch  out  1  instruction was BEQ/BNE.
- res_taken  out  1  branch condition true.
- res_illegal  out  1  instruction not supported.

## Operation
- Stage D register: alu_op, alu_in_0, alu_in_1, rd, we, branch, is_bne, illegal, d_valid.
- Stage R register: res_* outputs, r_valid (= res_valid).
- Decode (opcode = instr[6:0]):
  - 0110011 OP: funct7 0000000 → funct3 000 ADD, 100 XOR, 110 OR, 111 AND, 001 LSL, 101 LSR; funct7 0100000 + funct3 000 → SUB. in_0 = rs1, in_1 = rs2.
  - 0010011 OP-IMM: ADDI/XORI/ORI/ANDI use in_1 = sign-extended instr[31:20]. SLLI/SRLI require instr[31:25] = 0 and use in_1 = zero-extended instr[24:20].
  - 0110111 LUI: PASS_1, in_1 = {instr[31:12], 12'b0}.
  - 1100011 BEQ (funct3 000) / BNE (001): SUB, we=0, branch=1.
  - All other encodings (SLT*, SRA*, loads, BLT, etc.) are illegal: illegal=1, we=0, op=ADD, operands 0.
- Shift operands for OP are masked to {27'b0, rs2[4:0]} because the ALU shifts by the full operand.
- we = legal && !branch && rd != 0.
- R capture: res_data=alu_out; res_taken = branch & (is_bne ? !alu_zero : alu_zero); other fields are copied from D.

## Timing
- d_adv = d_valid && (!r_valid || res_ready); instr_ready = !flush && (!d_valid || d_adv) (combinational).
- Accept on edge ending cycle N → d_valid in N+1 → res_valid in N+2. Latency 2 and throughput 1/cycle with res_ready held high.
- res_ready low with r_valid high: R holds, D holds, and instr_ready drops once D is occupied. No data is lost or duplicated.
- Pop and load same cycle: R loads new D contents; res_valid stays 1.
- flush: d_valid and r_valid become 0 next edge. instr_ready is 0 during flush, so flush wins over simultaneous instr_valid.
- reset (any cycle, including mid-stall): all valids 0, all data registers 0, alu_op = ALU_ADD code, instr_ready = 1 the cycle after reset deasserts.
- alu_op/alu_in_* are driven from D registers only, never combinationally from instr.

## Structure
- ALU op codes come from the shared alu_codes.h; XLEN from RISCV.h. Opcode/funct constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_BRANCH) are added to RISCV.h.
- One combinational sub-module alu_decode (instr, rs1, rs2 → op, in_0, in_1, rd, we, branch, is_bne, illegal). Pipeline registers live in alu_issue.

## Test plan
- ADD x3,x1,x2 with rs1=5, rs2=7, res_ready=1 → res_valid 2 cycles after accept, res_data=12, res_rd=3, res_we=1.
- SLL with rs1=1, rs2=0x00000021 → alu_in_1=1, res_data=2. SRLI shamt 4 on 0x80000000 → 0x08000000.
- BNE with rs1=rs2=9 → res_branch=1, res_taken=0, res_we=0. BEQ with the same operands → res_taken=1.
- Back-to-back stream ADDI x1..x4 with res_ready low for 3 cycles → instr_ready low after D fills, all 4 results retire in order with no drops.
- SRA (funct7 0100000, funct3 101) → res_illegal=1, res_we=0. LUI 0x12345 → res_data=0x12345000.
- Assert flush while D and R are valid and instr_valid=1 → next cycle res_valid=0, instruction not accepted. Reset mid-stall → all outputs at their reset values.
